// File: rtl/vga_mode_ctrl_if.sv
// Host/sync-generator signal bundle for vga_mode_ctrl.
// slave = the controller, master = host plus sync generator side.
interface vga_mode_ctrl_if;
    localparam int unsigned CNT_W = 8;

    logic             i_req;
    logic             i_req_mode;
    logic             i_hmax;
    logic             i_vmax;
    logic             o_mode;
    logic             o_sync_reset;
    logic             o_blank;
    logic             o_busy;
    logic             o_ack;
    logic [CNT_W-1:0] o_switch_count;

    modport slave (
        input  i_req, i_req_mode, i_hmax, i_vmax,
        output o_mode, o_sync_reset, o_blank, o_busy, o_ack, o_switch_count
    );

    modport master (
        output i_req, i_req_mode, i_hmax, i_vmax,
        input  o_mode, o_sync_reset, o_blank, o_busy, o_ack, o_switch_count
    );
endinterface

// File: rtl/vga_mode_ctrl.sv
// Defers VGA mode changes to a frame boundary, then holds the sync generator
// in reset and forces blanking for a settle period while the monitor re-locks.
module vga_mode_ctrl #(
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic            clk,
    input  logic            reset,
    vga_mode_ctrl_if.slave  bus
);
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned EOF_W  = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {IDLE, WAIT_EOF, HOLD, SETTLE} state_e;

    state_e              state_q, state_d;
    logic                target_q, target_d;
    logic                q_valid_q, q_valid_d;
    logic                q_mode_q, q_mode_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [EOF_W-1:0]    eof_cnt_q, eof_cnt_d;
    logic                mode_q, mode_d;
    logic                sync_reset_q, sync_reset_d;
    logic                blank_q, blank_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [CNT_W-1:0]    switch_count_q, switch_count_d;

    logic eof_c, hold_done_c, settle_done_c, done_c;
    logic pend_valid_c, pend_mode_c, requeue_c;

    assign eof_c         = bus.i_hmax & bus.i_vmax;
    assign hold_done_c   = (state_q == HOLD) && (hold_cnt_q == '0);
    assign settle_done_c = (state_q == SETTLE) && eof_c
                           && (eof_cnt_q == EOF_W'(SETTLE_FRAMES - 1));
    assign done_c        = settle_done_c | (hold_done_c && (SETTLE_FRAMES == 0));
    // A request landing on the completion cycle is treated as already queued.
    assign pend_valid_c  = q_valid_q | bus.i_req;
    assign pend_mode_c   = bus.i_req ? bus.i_req_mode : q_mode_q;
    assign requeue_c     = done_c && pend_valid_c && (pend_mode_c != mode_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            target_q       <= 1'b0;
            q_valid_q      <= 1'b0;
            q_mode_q       <= 1'b0;
            hold_cnt_q     <= '0;
            eof_cnt_q      <= '0;
            mode_q         <= 1'b0;
            sync_reset_q   <= 1'b0;
            blank_q        <= 1'b0;
            busy_q         <= 1'b0;
            ack_q          <= 1'b0;
            switch_count_q <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            q_valid_q      <= q_valid_d;
            q_mode_q       <= q_mode_d;
            hold_cnt_q     <= hold_cnt_d;
            eof_cnt_q      <= eof_cnt_d;
            mode_q         <= mode_d;
            sync_reset_q   <= sync_reset_d;
            blank_q        <= blank_d;
            busy_q         <= busy_d;
            ack_q          <= ack_d;
            switch_count_q <= switch_count_d;
        end
    end

    // Next state, target, queue and counters
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        q_valid_d  = q_valid_q;
        q_mode_d   = q_mode_q;
        hold_cnt_d = hold_cnt_q;
        eof_cnt_d  = eof_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req && (bus.i_req_mode != mode_q)) begin
                    state_d  = WAIT_EOF;
                    target_d = bus.i_req_mode;
                end
            end
            WAIT_EOF: begin
                if (eof_c) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_W'(RESET_CYCLES - 1);
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    eof_cnt_d = '0;
                    state_d   = (SETTLE_FRAMES == 0) ? IDLE : SETTLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            SETTLE: begin
                if (eof_c) eof_cnt_d = eof_cnt_q + EOF_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && bus.i_req) begin
            q_valid_d = 1'b1;
            q_mode_d  = bus.i_req_mode;
        end
        if (done_c) begin
            q_valid_d = 1'b0;
            if (requeue_c) begin
                state_d  = WAIT_EOF;
                target_d = pend_mode_c;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    // Registered output values
    always_comb begin
        mode_d         = mode_q;
        sync_reset_d   = sync_reset_q;
        blank_d        = blank_q;
        ack_d          = 1'b0;
        switch_count_d = switch_count_q;
        busy_d         = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.i_req && (bus.i_req_mode == mode_q)) ack_d = 1'b1;
            end
            WAIT_EOF: begin
                if (eof_c) begin
                    mode_d         = target_q;
                    sync_reset_d   = 1'b1;
                    blank_d        = 1'b1;
                    switch_count_d = switch_count_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) sync_reset_d = 1'b0;
            end
            default: ;
        endcase
        if (done_c) begin
            blank_d = 1'b0;
            ack_d   = 1'b1;
        end
    end

    assign bus.o_mode         = mode_q;
    assign bus.o_sync_reset   = sync_reset_q;
    assign bus.o_blank        = blank_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_ack          = ack_q;
    assign bus.o_switch_count = switch_count_q;
endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: default build (A) and a
// RESET_CYCLES=1 / SETTLE_FRAMES=0 build (B).
module tb_vga_mode_ctrl;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   acks_a = 0;
    int   acks_b = 0;

    vga_mode_ctrl_if a ();
    vga_mode_ctrl_if b ();

    vga_mode_ctrl #(.RESET_CYCLES(4), .SETTLE_FRAMES(2)) dut_a (
        .clk(clk), .reset(rst_a), .bus(a.slave)
    );
    vga_mode_ctrl #(.RESET_CYCLES(1), .SETTLE_FRAMES(0)) dut_b (
        .clk(clk), .reset(rst_b), .bus(b.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        acks_a += int'(a.o_ack);
        acks_b += int'(b.o_ack);
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        tick();
        rst_a  = 1'b0;
        acks_a = 0;
    endtask

    task automatic req_a(input logic m);
        a.i_req = 1'b1; a.i_req_mode = m;
        tick();
        a.i_req = 1'b0;
    endtask

    task automatic eof_a();
        a.i_hmax = 1'b1; a.i_vmax = 1'b1;
        tick();
        a.i_hmax = 1'b0; a.i_vmax = 1'b0;
    endtask

    task automatic req_b(input logic m);
        b.i_req = 1'b1; b.i_req_mode = m;
        tick();
        b.i_req = 1'b0;
    endtask

    task automatic eof_b();
        b.i_hmax = 1'b1; b.i_vmax = 1'b1;
        tick();
        b.i_hmax = 1'b0; b.i_vmax = 1'b0;
    endtask

    initial begin
        logic m;
        a.i_req = 0; a.i_req_mode = 0; a.i_hmax = 0; a.i_vmax = 0;
        b.i_req = 0; b.i_req_mode = 0; b.i_hmax = 0; b.i_vmax = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        tick();
        tick();
        check("rst_mode",  a.o_mode, 0);
        check("rst_sync",  a.o_sync_reset, 0);
        check("rst_blank", a.o_blank, 0);
        check("rst_busy",  a.o_busy, 0);
        check("rst_ack",   a.o_ack, 0);
        check("rst_count", a.o_switch_count, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        acks_a = 0; acks_b = 0;

        // 1: same-mode request is an immediate ack
        req_a(1'b0);
        check("noop_ack",   a.o_ack, 1);
        check("noop_busy",  a.o_busy, 0);
        check("noop_blank", a.o_blank, 0);
        check("noop_sync",  a.o_sync_reset, 0);
        check("noop_count", a.o_switch_count, 0);
        tick();
        check("noop_ack_drop", a.o_ack, 0);

        // 2: full mode change 0 -> 1
        req_a(1'b1);
        check("wait_busy",  a.o_busy, 1);
        check("wait_blank", a.o_blank, 0);
        check("wait_mode",  a.o_mode, 0);
        a.i_hmax = 1'b1; tick(); a.i_hmax = 1'b0;
        check("hmax_only", a.o_sync_reset, 0);
        a.i_vmax = 1'b1; tick(); a.i_vmax = 1'b0;
        check("vmax_only", a.o_sync_reset, 0);
        eof_a();
        check("e1_mode",  a.o_mode, 1);
        check("e1_sync",  a.o_sync_reset, 1);
        check("e1_blank", a.o_blank, 1);
        check("e1_count", a.o_switch_count, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("hold_e%0d", i), a.o_sync_reset, 1);
        end
        tick();
        check("e5_sync",  a.o_sync_reset, 0);
        check("e5_blank", a.o_blank, 1);
        eof_a();
        check("settle1_blank", a.o_blank, 1);
        check("settle1_ack",   a.o_ack, 0);
        tick();
        tick();
        eof_a();
        check("done_blank", a.o_blank, 0);
        check("done_ack",   a.o_ack, 1);
        check("done_busy",  a.o_busy, 0);
        check("done_count", a.o_switch_count, 1);
        tick();
        check("done_ack_drop", a.o_ack, 0);
        check("t2_acks", acks_a, 2);

        // 3: opposite request queued during HOLD re-enters WAIT_EOF
        reset_a();
        req_a(1'b1);
        eof_a();
        req_a(1'b0);
        tick(); tick(); tick();
        eof_a();
        eof_a();
        check("t3_ack1",  a.o_ack, 1);
        check("t3_busy",  a.o_busy, 1);
        check("t3_blank", a.o_blank, 0);
        check("t3_mode1", a.o_mode, 1);
        tick();
        eof_a();
        check("t3_mode0", a.o_mode, 0);
        check("t3_count", a.o_switch_count, 2);
        tick(); tick(); tick(); tick();
        eof_a();
        eof_a();
        check("t3_idle", a.o_busy, 0);
        check("t3_acks", acks_a, 2);

        // 4: same mode queued during SETTLE collapses into one ack
        reset_a();
        req_a(1'b1);
        eof_a();
        tick(); tick(); tick(); tick();
        req_a(1'b1);
        eof_a();
        eof_a();
        check("t4_ack", a.o_ack, 1);
        check("t4_busy", a.o_busy, 0);
        tick(); tick();
        check("t4_busy_later", a.o_busy, 0);
        check("t4_count", a.o_switch_count, 1);
        check("t4_acks", acks_a, 1);

        // request on the completion cycle counts as queued
        reset_a();
        req_a(1'b1);
        eof_a();
        tick(); tick(); tick(); tick();
        eof_a();
        a.i_req = 1'b1; a.i_req_mode = 1'b0;
        eof_a();
        a.i_req = 1'b0;
        check("cq_ack",  a.o_ack, 1);
        check("cq_busy", a.o_busy, 1);
        eof_a();
        check("cq_mode", a.o_mode, 0);

        // 5: reset during SETTLE
        reset_a();
        req_a(1'b1);
        eof_a();
        tick(); tick(); tick(); tick();
        check("t5_in_settle", a.o_blank, 1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("t5_mode",  a.o_mode, 0);
        check("t5_blank", a.o_blank, 0);
        check("t5_busy",  a.o_busy, 0);
        check("t5_count", a.o_switch_count, 0);
        check("t5_sync",  a.o_sync_reset, 0);
        tick();
        check("t5_acks", acks_a, 0);

        // request on an IDLE EOF waits for the next EOF
        a.i_req = 1'b1; a.i_req_mode = 1'b1; a.i_hmax = 1'b1; a.i_vmax = 1'b1;
        tick();
        a.i_req = 1'b0; a.i_hmax = 1'b0; a.i_vmax = 1'b0;
        check("reqeof_busy", a.o_busy, 1);
        check("reqeof_sync", a.o_sync_reset, 0);
        eof_a();
        check("reqeof_next", a.o_sync_reset, 1);

        // 6: RESET_CYCLES=1, SETTLE_FRAMES=0
        req_b(1'b1);
        eof_b();
        check("b_e1_sync",  b.o_sync_reset, 1);
        check("b_e1_blank", b.o_blank, 1);
        check("b_e1_ack",   b.o_ack, 0);
        tick();
        check("b_e2_sync",  b.o_sync_reset, 0);
        check("b_e2_ack",   b.o_ack, 1);
        check("b_e2_blank", b.o_blank, 0);
        check("b_e2_busy",  b.o_busy, 0);
        check("b_e2_mode",  b.o_mode, 1);
        m = 1'b1;
        for (int i = 0; i < 254; i++) begin
            m = ~m;
            req_b(m);
            eof_b();
            tick();
        end
        check("b_count_255", b.o_switch_count, 255);
        m = ~m;
        req_b(m);
        eof_b();
        tick();
        check("b_count_wrap", b.o_switch_count, 0);
        check("b_acks", acks_b, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
Sequences timing-mode changes for the VGA sync generator. Mode 0 is 640x480@60 and mode 1 is 1440x900@60 div-4.
- Accepts mode-change requests and defers each one to a frame boundary.
- Holds the sync generator in reset for a fixed number of cycles, applies the new mode, then forces video blanking for a settle period so the monitor can re-lock.
- Sits between the host/config logic and the sync generator's `mode` and `reset` inputs.

Parameters:
- RESET_CYCLES, default 4: cycles `o_sync_reset` is held high after a mode change; legal range 1..255.
- SETTLE_FRAMES, default 2: complete frames of forced blanking after the sync reset is released; legal range 0..15.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- i_req  in  1  mode-change request strobe, sampled every cycle
- i_req_mode  in  1  requested mode, valid when `i_req`=1
- i_hmax  in  1  sync generator "last pixel of line" flag
- i_vmax  in  1  sync generator "last line of frame" flag
- o_mode  out  1  mode driven to the sync generator
- o_sync_reset  out  1  ORed into the sync generator reset
- o_blank  out  1  forces RGB output to black
- o_busy  out  1  high whenever state is not IDLE
- o_ack  out  1  one-cycle pulse on completion of a request
- o_switch_count  out  8  number of mode changes applied; wraps at 255 -> 0

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, `o_mode`=0, `o_sync_reset`=0, `o_blank`=0, `o_busy`=0, `o_ack`=0, `o_switch_count`=0, queue empty.
- Frame end (EOF) is the cycle where `i_hmax` & `i_vmax` = 1.

States: IDLE, WAIT_EOF, HOLD, SETTLE.

IDLE:
- `i_req` with `i_req_mode`==`o_mode`: this is a no-op. `o_ack`=1 on the next cycle; stay in IDLE.
- `i_req` with a differing mode: latch the target, go to WAIT_EOF next cycle, `o_busy`=1.

WAIT_EOF:
- On EOF at cycle e: in cycle e+1 the state is HOLD, with `o_mode`=target, `o_sync_reset`=1, `o_blank`=1, and `o_switch_count` incremented.
- `o_blank` stays 0 while waiting, so the current frame completes normally.

HOLD:
- `o_sync_reset` is high for exactly RESET_CYCLES cycles (e+1 .. e+RESET_CYCLES).
- In cycle e+RESET_CYCLES+1: `o_sync_reset`=0. The state is SETTLE, or IDLE if SETTLE_FRAMES=0 (completion rules apply).
- `i_hmax`/`i_vmax` are ignored in HOLD.

SETTLE:
- `o_blank`=1 throughout.
- Count EOF cycles. On the SETTLE_FRAMES-th EOF at cycle f, completion takes effect in f+1: `o_blank`=0, `o_ack`=1 for one cycle, state IDLE, `o_busy`=0.

Requests while busy:
- A single-entry queue captures the last `i_req`/`i_req_mode` (last wins); the in-progress target is not altered.
- At completion, if the queue is non-empty and its mode differs from `o_mode`: the queue is cleared, the state goes to WAIT_EOF instead of IDLE, `o_busy` stays 1, and `o_ack` still pulses for the completed change.
- If the queued mode equals `o_mode`: the queue is cleared, state goes to IDLE, and one `o_ack` covers both requests.
- A request arriving in the same cycle as completion counts as queued.

Other rules:
- `i_req` in the same cycle as EOF in IDLE: the request enters WAIT_EOF and waits for the next EOF; the current EOF is not used.
- `reset` mid-operation returns everything to reset values next cycle, including `o_mode`=0. The queue is discarded and no `o_ack` is issued.
- The EOF counter is 4 bits. The hold counter is 8 bits, loaded with RESET_CYCLES-1 and decremented to 0.

Test Plan:
1. Reset, then `i_req`=1 with `i_req_mode`=0 -> `o_ack`=1 one cycle later; `o_busy`, `o_blank` and `o_sync_reset` stay 0; `o_switch_count`=0.
2. Request mode 1, then EOF at cycle e -> `o_mode`=1 from e+1; `o_sync_reset` high e+1..e+4; `o_blank` high from e+1 until the cycle after the 2nd SETTLE EOF; `o_ack` pulses then; `o_switch_count`=1.
3. Request mode 1, then mode 0 during HOLD -> first change completes with `o_ack`; `o_busy` stays 1; WAIT_EOF re-entered; next EOF applies `o_mode`=0; `o_switch_count`=2; two acks total.
4. Request mode 1, then mode 1 again during SETTLE -> single `o_ack`; IDLE after completion; `o_switch_count`=1.
5. Assert `reset` during SETTLE -> next cycle `o_mode`=0, `o_blank`=0, `o_busy`=0, `o_switch_count`=0, and no `o_ack`.
6. Build with SETTLE_FRAMES=0, RESET_CYCLES=1 -> `o_sync_reset` high only at e+1; at e+2 `o_ack`=1, `o_blank`=0, state IDLE. Also run 256 switches and check `o_switch_count` wraps to 0.
